// File: rtl/se_sram_pkg.sv
// Shared definitions for the se_sram family: sweep-state encoding, lane-count
// helper and the supported read latencies.
package se_sram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } sweep_state_e;

   localparam int unsigned LATENCY_SHORT = 1;
   localparam int unsigned LATENCY_LONG  = 2;

   function automatic int unsigned lane_count(input int unsigned data_width,
                                              input int unsigned byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/se_sram_clear_sequencer.sv
// Post-reset clear sweep: walks every word address once, then declares the
// array ready for requests.
module se_sram_clear_sequencer
   import se_sram_pkg::*;
#(
   parameter int unsigned address_width  = 14,
   parameter bit          clear_on_reset = 1'b1
) (
   input  logic                     sram_clock,
   input  logic                     sram_reset,
   input  logic                     clock_enable,
   output logic                     clear_active,
   output logic [address_width-1:0] clear_address,
   output logic                     ready
);

   localparam int unsigned counter_width = address_width + 1;
   localparam logic [counter_width-1:0] last_address =
      counter_width'((64'd1 << address_width) - 64'd1);

   sweep_state_e             state;
   logic [counter_width-1:0] counter;

   always_ff @(posedge sram_clock) begin
      if (sram_reset) begin
         counter <= '0;
         if (clear_on_reset) begin
            state        <= CLEAR;
            clear_active <= 1'b1;
            ready        <= 1'b0;
         end else begin
            state        <= READY;
            clear_active <= 1'b0;
            ready        <= 1'b1;
         end
      end else if (clock_enable) begin
         case (state)
            CLEAR: begin
               counter <= counter + counter_width'(1);
               if (counter == last_address) begin
                  state        <= READY;
                  clear_active <= 1'b0;
                  ready        <= 1'b1;
               end
            end
            READY: begin
               state <= READY;
            end
            default: begin
               state <= READY;
            end
         endcase
      end
   end

   // Extra counter bit only guards the terminal compare; the array sees the low bits.
   assign clear_address = counter[address_width-1:0];

endmodule

// File: rtl/se_sram_srw_we_init.sv
// Single-port synchronous SRAM with byte-lane write enables, optional
// post-reset clear sweep and a 1- or 2-cycle registered read path.
module se_sram_srw_we_init
   import se_sram_pkg::*;
#(
   parameter int unsigned            address_width  = 14,
   parameter int unsigned            data_width     = 32,
   parameter int unsigned            byte_width     = 8,
   parameter int unsigned            read_latency   = 1,
   parameter bit                     clear_on_reset = 1'b1,
   parameter logic [data_width-1:0]  clear_value    = '0,
   parameter string                  initfile       = ""
) (
   input  logic                                         sram_clock,
   input  logic                                         sram_reset,
   input  logic                                         sram_clock__enable,
   input  logic                                         select,
   input  logic                                         read_not_write,
   input  logic [lane_count(data_width, byte_width)-1:0] write_enable,
   input  logic [address_width-1:0]                     address,
   input  logic [data_width-1:0]                        write_data,
   output logic [data_width-1:0]                        data_out,
   output logic                                         data_valid,
   output logic                                         ready
);

   localparam int unsigned lanes = lane_count(data_width, byte_width);
   localparam int unsigned depth = 1 << address_width;

   if (read_latency != LATENCY_SHORT && read_latency != LATENCY_LONG) begin : g_bad_latency
      $error("se_sram_srw_we_init: read_latency must be 1 or 2");
   end
   if (data_width % byte_width != 0) begin : g_bad_lanes
      $error("se_sram_srw_we_init: data_width must be a multiple of byte_width");
   end
   // Preload content comes from the memory macro's own loader; nothing to build here.
   if (initfile != "") begin : g_preload
   end

   logic                     clear_active;
   logic [address_width-1:0] clear_address;

   se_sram_clear_sequencer #(
      .address_width (address_width),
      .clear_on_reset(clear_on_reset)
   ) u_clear_sequencer (
      .sram_clock   (sram_clock),
      .sram_reset   (sram_reset),
      .clock_enable (sram_clock__enable),
      .clear_active (clear_active),
      .clear_address(clear_address),
      .ready        (ready)
   );

   logic                     accept_c;
   logic                     rd_accept_c;
   logic                     wr_en_c;
   logic [address_width-1:0] wr_addr_c;
   logic [data_width-1:0]    wr_data_c;
   logic [lanes-1:0]         wr_lanes_c;

   assign accept_c    = ready & select & sram_clock__enable;
   assign rd_accept_c = accept_c & read_not_write;

   // Write port arbitration: the sweep owns the port until ready.
   always_comb begin
      wr_en_c    = 1'b0;
      wr_addr_c  = address;
      wr_data_c  = write_data;
      wr_lanes_c = write_enable;
      if (clear_active) begin
         wr_en_c    = sram_clock__enable & ~sram_reset;
         wr_addr_c  = clear_address;
         wr_data_c  = clear_value;
         wr_lanes_c = '1;
      end else begin
         wr_en_c    = accept_c & ~read_not_write & ~sram_reset;
      end
   end

   logic [data_width-1:0] mem [depth];

   always_ff @(posedge sram_clock) begin
      if (wr_en_c) begin
         for (int unsigned i = 0; i < lanes; i++) begin
            if (wr_lanes_c[i]) begin
               mem[wr_addr_c][i*byte_width +: byte_width] <= wr_data_c[i*byte_width +: byte_width];
            end
         end
      end
   end

   logic                  cap_valid;
   logic [data_width-1:0] cap_data;

   // First read stage: registered array output.
   always_ff @(posedge sram_clock) begin
      if (sram_reset) begin
         cap_valid <= 1'b0;
         cap_data  <= '0;
      end else if (sram_clock__enable) begin
         cap_valid <= rd_accept_c;
         if (rd_accept_c) begin
            cap_data <= mem[address];
         end
      end
   end

   if (read_latency == LATENCY_LONG) begin : g_latency2
      always_ff @(posedge sram_clock) begin
         if (sram_reset) begin
            data_valid <= 1'b0;
            data_out   <= '0;
         end else if (sram_clock__enable) begin
            data_valid <= cap_valid;
            if (cap_valid) begin
               data_out <= cap_data;
            end
         end
      end
   end else begin : g_latency1
      assign data_valid = cap_valid;
      assign data_out   = cap_data;
   end

endmodule

// File: tb/tb_se_sram_srw_we_init.sv
// Bench for se_sram_srw_we_init: latency-1 and latency-2 instances share one
// stimulus stream and are checked against a queue-based memory model.
module tb_se_sram_srw_we_init;

   localparam int unsigned depth = 16;
   localparam logic [31:0] cval  = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst, en, sel, rnw;
   logic [3:0]  we;
   logic [3:0]  addr;
   logic [31:0] wd;
   logic [31:0] out1, out2;
   logic        v1, v2, rdy1, rdy2;

   always #5 clk = ~clk;

   se_sram_srw_we_init #(
      .address_width(4), .data_width(32), .byte_width(8), .read_latency(1),
      .clear_on_reset(1'b1), .clear_value(cval), .initfile("")
   ) dut1 (
      .sram_clock(clk), .sram_reset(rst), .sram_clock__enable(en), .select(sel),
      .read_not_write(rnw), .write_enable(we), .address(addr), .write_data(wd),
      .data_out(out1), .data_valid(v1), .ready(rdy1)
   );

   se_sram_srw_we_init #(
      .address_width(4), .data_width(32), .byte_width(8), .read_latency(2),
      .clear_on_reset(1'b1), .clear_value(cval), .initfile("")
   ) dut2 (
      .sram_clock(clk), .sram_reset(rst), .sram_clock__enable(en), .select(sel),
      .read_not_write(rnw), .write_enable(we), .address(addr), .write_data(wd),
      .data_out(out2), .data_valid(v2), .ready(rdy2)
   );

   // Reference model: word array, sweep progress and in-flight reads tagged with the
   // enabled-edge number on which their result must appear.
   typedef struct packed {
      logic [31:0] d;
      int          due;
   } pend_t;

   logic [31:0] mem_m [depth];
   pend_t       q1[$];
   pend_t       q2[$];
   int          en_count, sweep_edges;
   logic        e_rdy = 1'b0, e_v1 = 1'b0, e_v2 = 1'b0;
   logic [31:0] e_out1 = '0, e_out2 = '0;
   int          total = 0, bad = 0;

   task automatic tick();
      bit    acc;
      pend_t p;
      acc = !rst && en && sel && e_rdy;
      @(posedge clk);
      if (rst) begin
         en_count = 0; sweep_edges = 0; e_rdy = 1'b0;
         q1.delete(); q2.delete();
         e_v1 = 1'b0; e_v2 = 1'b0; e_out1 = '0; e_out2 = '0;
      end else if (en) begin
         en_count++;
         e_v1 = 1'b0; e_v2 = 1'b0;
         if (acc && rnw) begin
            p.d = mem_m[addr]; p.due = en_count;     q1.push_back(p);
            p.d = mem_m[addr]; p.due = en_count + 1; q2.push_back(p);
         end
         if (acc && !rnw) begin
            for (int i = 0; i < 4; i++) if (we[i]) mem_m[addr][i*8 +: 8] = wd[i*8 +: 8];
         end
         if (q1.size() > 0 && q1[0].due == en_count) begin
            e_v1 = 1'b1; e_out1 = q1[0].d; void'(q1.pop_front());
         end
         if (q2.size() > 0 && q2[0].due == en_count) begin
            e_v2 = 1'b1; e_out2 = q2[0].d; void'(q2.pop_front());
         end
         if (!e_rdy) begin
            mem_m[sweep_edges] = cval;
            sweep_edges++;
            if (sweep_edges == depth) e_rdy = 1'b1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; sel = 1'b0;
      tick();
      total++;
      if ({rdy1, v1, out1, rdy2, v2, out2} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL reset_state: got rdy=%b/%b v=%b/%b d=%h/%h want all zero",
                  rdy1, rdy2, v1, v2, out1, out2);
      end
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         sel = 1'b1; rnw = 1'b0; we = 4'hF; addr = 4'(k); wd = $urandom;
         tick();
         total++;
         if (rdy1 !== (k == 15) || rdy2 !== (k == 15)) begin
            bad++;
            $display("FAIL sweep_ready cyc %0d: got %b/%b want %b", k, rdy1, rdy2, k == 15);
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_sweep_contents();
      int n1 = 0, n2 = 0;
      for (int k = 0; k < 19; k++) begin
         sel = (k < 16); rnw = 1'b1; addr = 4'(k);
         tick();
         if (v1 === 1'b1) n1++;
         if (v2 === 1'b1) n2++;
         total++;
         if ({rdy1, v1, out1, v2, out2} !== {e_rdy, e_v1, e_out1, e_v2, e_out2}) begin
            bad++;
            $display("FAIL sweep_read cyc %0d: got v=%b/%b d=%h/%h want v=%b/%b d=%h/%h",
                     k, v1, v2, out1, out2, e_v1, e_v2, e_out1, e_out2);
         end
      end
      total++;
      if (n1 != 16 || n2 != 16 || out1 !== cval || out2 !== cval) begin
         bad++;
         $display("FAIL sweep_count: got %0d/%0d d=%h/%h want 16/16 d=%h", n1, n2, out1, out2, cval);
      end
      sel = 1'b0;
   endtask

   task automatic test_byte_lanes();
      logic [31:0] got = '0;
      sel = 1'b1; rnw = 1'b0; addr = 4'd5; we = 4'b1111; wd = 32'h11223344; tick();
      we = 4'b0101; wd = 32'hAABBCCDD; tick();
      we = 4'b0000; wd = 32'hFFFFFFFF; tick();
      rnw = 1'b1; tick();
      sel = 1'b0;
      if (v1 === 1'b1) got = out1;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if ({v1, out1, v2, out2} !== {e_v1, e_out1, e_v2, e_out2}) begin
            bad++;
            $display("FAIL lanes_read cyc %0d: got v=%b/%b d=%h/%h want v=%b/%b d=%h/%h",
                     k, v1, v2, out1, out2, e_v1, e_v2, e_out1, e_out2);
         end
      end
      total++;
      if (got !== 32'h11BB33DD || out2 !== 32'h11BB33DD) begin
         bad++;
         $display("FAIL lanes_value: got %h/%h want 11bb33dd", got, out2);
      end
   endtask

   task automatic test_back_to_back();
      for (int a = 1; a <= 3; a++) begin
         sel = 1'b1; rnw = 1'b0; we = 4'hF; addr = 4'(a); wd = $urandom; tick();
      end
      for (int k = 0; k < 6; k++) begin
         sel = (k < 3); rnw = 1'b1; addr = 4'(k + 1);
         tick();
         total++;
         if ({v1, out1, v2, out2} !== {e_v1, e_out1, e_v2, e_out2} || v2 !== (k >= 1 && k <= 3)) begin
            bad++;
            $display("FAIL b2b cyc %0d: got v=%b/%b d=%h/%h want v=%b/%b d=%h/%h",
                     k, v1, v2, out1, out2, e_v1, e_v2, e_out1, e_out2);
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_clock_enable();
      sel = 1'b1; rnw = 1'b0; we = 4'hF; addr = 4'd9; wd = 32'hC0FFEE09; tick();
      rnw = 1'b1; tick();
      sel = 1'b0;
      for (int k = 0; k < 6; k++) begin
         en = (k >= 3);
         tick();
         total++;
         if ({v1, out1, v2, out2} !== {e_v1, e_out1, e_v2, e_out2} || v2 !== (k == 3)) begin
            bad++;
            $display("FAIL clock_enable cyc %0d: got v=%b/%b d=%h/%h want v=%b/%b d=%h/%h",
                     k, v1, v2, out1, out2, e_v1, e_v2, e_out1, e_out2);
         end
      end
      en = 1'b1;
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         en = ($urandom_range(0, 3) != 0); sel = $urandom_range(0, 1);
         rnw = $urandom_range(0, 1); we = 4'($urandom_range(0, 15));
         addr = 4'($urandom_range(0, 15)); wd = $urandom;
         tick();
         total++;
         if ({rdy1, v1, out1, rdy2, v2, out2} !== {e_rdy, e_v1, e_out1, e_rdy, e_v2, e_out2}) begin
            bad++;
            $display("FAIL random cyc %0d: got v=%b/%b d=%h/%h want v=%b/%b d=%h/%h",
                     k, v1, v2, out1, out2, e_v1, e_v2, e_out1, e_out2);
         end
      end
      en = 1'b1; sel = 1'b0;
   endtask

   task automatic test_reset_flush();
      sel = 1'b1; rnw = 1'b1; addr = 4'd5; tick();
      sel = 1'b0; rst = 1'b1; tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({v1, out1, v2, out2, rdy2} !== {1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_flush cyc %0d: got v=%b/%b d=%h/%h want 0", k, v1, v2, out1, out2);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n2 = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         sel = 1'b1; rnw = $urandom_range(0, 1); we = 4'hF; addr = 4'($urandom_range(0, 15)); wd = $urandom;
         tick();
         total++;
         if ({rdy1, rdy2, v1, v2} !== {e_rdy, e_rdy, 1'b0, 1'b0} || rdy2 !== (k == 15)) begin
            bad++;
            $display("FAIL mid_sweep cyc %0d: got rdy=%b/%b v=%b/%b want rdy=%b v=0",
                     k, rdy1, rdy2, v1, v2, k == 15);
         end
      end
      for (int k = 0; k < 18; k++) begin
         sel = (k < 16); rnw = 1'b1; addr = 4'(k);
         tick();
         if (v2 === 1'b1 && out2 === cval) n2++;
         total++;
         if ({v1, out1, v2, out2} !== {e_v1, e_out1, e_v2, e_out2}) begin
            bad++;
            $display("FAIL mid_sweep_read cyc %0d: got v=%b/%b d=%h/%h want v=%b/%b d=%h/%h",
                     k, v1, v2, out1, out2, e_v1, e_v2, e_out1, e_out2);
         end
      end
      total++;
      if (n2 != 16) begin
         bad++;
         $display("FAIL mid_sweep_contents: got %0d clear words want 16", n2);
      end
      sel = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; sel = 1'b0; rnw = 1'b1; we = '0; addr = '0; wd = '0;
      test_reset();
      test_sweep_contents();
      test_byte_lanes();
      test_back_to_back();
      test_clock_enable();
      test_random();
      test_reset_flush();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
